// File: rtl/issue_ctrl_pkg.sv
// Shared types for the issue controller: destination zones, FSM states and
// register-index helpers used by the pending-load scoreboard.
package issue_ctrl_pkg;

  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam int ZONE_W = 2;

  typedef enum logic [ZONE_W-1:0] {
    ZONE_REGFILE = 2'd0,
    ZONE_LOADQ   = 2'd1,
    ZONE_STOREQ  = 2'd2
  } zone_e;

  typedef enum logic [1:0] {
    ISSUE_ST_RUN       = 2'd0,
    ISSUE_ST_JUMP_WAIT = 2'd1,
    ISSUE_ST_TRAP      = 2'd2
  } issue_st_e;

  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    return NREG'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register that is waiting
// on a load write-back, plus a count of loads currently outstanding.
module regfile_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter  int C_LQ_DEPTH = 4,
  localparam int CNT_W      = $clog2(C_LQ_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              ld_issue_i,
  input  logic [REG_AW-1:0] ld_addr_i,
  input  logic              ld_wb_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              rs1_hit_o,
  output logic              rs2_hit_o,
  output logic              rd_hit_o,
  output logic              ld_full_o,
  output logic              ld_empty_o,
  output logic [CNT_W-1:0]  ld_cnt_o,
  output logic [NREG-1:0]   pending_o
);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [NREG-1:0]  set_mask, clr_mask;

  // Set is applied after clear so a same-register set/clear leaves the bit set;
  // bit 0 is forced low so x0 never stalls anything.
  always_comb begin
    set_mask  = ld_issue_i ? reg_onehot(ld_addr_i) : '0;
    clr_mask  = ld_wb_i    ? reg_onehot(wb_addr_i) : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (ld_issue_i && !ld_wb_i) begin
      ld_cnt_d = ld_cnt_q + CNT_W'(1);
    end else if (!ld_issue_i && ld_wb_i) begin
      ld_cnt_d = ld_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      pending_q <= '0;
      ld_cnt_q  <= '0;
    end else begin
      pending_q <= pending_d;
      ld_cnt_q  <= ld_cnt_d;
    end
  end

  assign rs1_hit_o  = pending_q[rs1_addr_i];
  assign rs2_hit_o  = pending_q[rs2_addr_i];
  assign rd_hit_o   = pending_q[rd_addr_i];
  assign ld_full_o  = (ld_cnt_q == CNT_W'(C_LQ_DEPTH));
  assign ld_empty_o = (ld_cnt_q == '0);
  assign ld_cnt_o   = ld_cnt_q;
  assign pending_o  = pending_q;

  a_ld_cnt_no_overflow: assert property (
    @(posedge clk_i) disable iff (!resetb_i)
    (ld_issue_i && !ld_wb_i) |-> (ld_cnt_q != CNT_W'(C_LQ_DEPTH))
  ) else $error("load counter overflow");

  a_ld_cnt_no_underflow: assert property (
    @(posedge clk_i) disable iff (!resetb_i)
    (ld_wb_i && !ld_issue_i) |-> (ld_cnt_q != '0)
  ) else $error("load counter underflow");

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: holds decoded instructions on load hazards, serialises CSR
// access and jumps, and parks illegal instructions until the trap unit acks.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter  int C_LQ_DEPTH = 4,
  localparam int CNT_W      = $clog2(C_LQ_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              ids_valid_i,
  output logic              ids_ready_o,
  input  logic              ins_err_i,
  input  logic              jump_i,
  input  logic [ZONE_W-1:0] zone_i,
  input  logic [REG_AW-1:0] regd_addr_i,
  input  logic              regs1_rd_i,
  input  logic [REG_AW-1:0] regs1_addr_i,
  input  logic              regs2_rd_i,
  input  logic [REG_AW-1:0] regs2_addr_i,
  input  logic              csr_rd_i,
  input  logic              csr_wr_i,
  output logic              exs_valid_o,
  input  logic              exs_ready_i,
  input  logic              lq_full_i,
  input  logic              lq_wb_valid_i,
  input  logic [REG_AW-1:0] lq_wb_addr_i,
  input  logic              jump_done_i,
  output logic              trap_o,
  input  logic              trap_ack_i,
  output issue_st_e         dbg_state_o,
  output logic [NREG-1:0]   dbg_pending_o,
  output logic [CNT_W-1:0]  dbg_ld_cnt_o
);

  // Handshake: exs_valid_o is built only from state and decoder inputs, never
  // from exs_ready_i; an instruction moves when exs_valid_o & exs_ready_i
  // (issue). ids_ready_o tells the decoder its instruction left this cycle,
  // either issued or dropped after a trap ack. Both sides are zero latency.
  issue_st_e state_q, state_d;
  logic rs1_hit, rs2_hit, rd_hit, ld_full, ld_empty;
  logic is_load, raw, waw, ldblk, csrblk, hazard;
  logic issue, drop;

  assign is_load = (zone_i == ZONE_LOADQ);
  assign raw     = (regs1_rd_i & rs1_hit) | (regs2_rd_i & rs2_hit);
  assign waw     = rd_hit;
  assign ldblk   = is_load & (lq_full_i | ld_full);
  assign csrblk  = (csr_rd_i | csr_wr_i) & ~ld_empty;
  assign hazard  = raw | waw | ldblk | csrblk;

  regfile_scoreboard #(
    .C_LQ_DEPTH (C_LQ_DEPTH)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .resetb_i   (resetb_i),
    .ld_issue_i (issue & is_load),
    .ld_addr_i  (regd_addr_i),
    .ld_wb_i    (lq_wb_valid_i),
    .wb_addr_i  (lq_wb_addr_i),
    .rs1_addr_i (regs1_addr_i),
    .rs2_addr_i (regs2_addr_i),
    .rd_addr_i  (regd_addr_i),
    .rs1_hit_o  (rs1_hit),
    .rs2_hit_o  (rs2_hit),
    .rd_hit_o   (rd_hit),
    .ld_full_o  (ld_full),
    .ld_empty_o (ld_empty),
    .ld_cnt_o   (dbg_ld_cnt_o),
    .pending_o  (dbg_pending_o)
  );

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= ISSUE_ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE_ST_RUN: begin
        if (ids_valid_i && ins_err_i) begin
          state_d = ISSUE_ST_TRAP;
        end else if (issue && jump_i) begin
          state_d = ISSUE_ST_JUMP_WAIT;
        end
      end
      ISSUE_ST_JUMP_WAIT: begin
        if (jump_done_i) state_d = ISSUE_ST_RUN;
      end
      ISSUE_ST_TRAP: begin
        if (trap_ack_i) state_d = ISSUE_ST_RUN;
      end
      default: state_d = ISSUE_ST_RUN;
    endcase
  end

  always_comb begin
    exs_valid_o = 1'b0;
    trap_o      = 1'b0;
    drop        = 1'b0;
    case (state_q)
      ISSUE_ST_RUN: begin
        exs_valid_o = ids_valid_i & ~ins_err_i & ~hazard;
      end
      ISSUE_ST_TRAP: begin
        trap_o = 1'b1;
        drop   = trap_ack_i;
      end
      default: begin
        exs_valid_o = 1'b0;
      end
    endcase
  end

  assign issue       = exs_valid_o & exs_ready_i;
  assign ids_ready_o = issue | drop;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: stimulus pushes expected issue tags, a monitor
// pops them at each handshake; per-cycle handshake and state checks alongside.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int TAG_W = ZONE_W + 3 * REG_AW;

  logic              clk_i = 1'b0;
  logic              resetb_i;
  logic              ids_valid_i, ids_ready_o, ins_err_i, jump_i;
  logic [ZONE_W-1:0] zone_i;
  logic [REG_AW-1:0] regd_addr_i, regs1_addr_i, regs2_addr_i, lq_wb_addr_i;
  logic              regs1_rd_i, regs2_rd_i, csr_rd_i, csr_wr_i;
  logic              exs_valid_o, exs_ready_i, lq_full_i, lq_wb_valid_i;
  logic              jump_done_i, trap_o, trap_ack_i;
  issue_st_e         dbg_state_o;
  logic [NREG-1:0]   dbg_pending_o;
  logic [2:0]        dbg_ld_cnt_o;

  logic [TAG_W-1:0] exp_q[$];
  logic [TAG_W-1:0] mon_exp;
  int n_tests = 0;
  int n_fail  = 0;

  issue_ctrl #(.C_LQ_DEPTH(4)) dut (
    .clk_i(clk_i), .resetb_i(resetb_i),
    .ids_valid_i(ids_valid_i), .ids_ready_o(ids_ready_o),
    .ins_err_i(ins_err_i), .jump_i(jump_i), .zone_i(zone_i),
    .regd_addr_i(regd_addr_i),
    .regs1_rd_i(regs1_rd_i), .regs1_addr_i(regs1_addr_i),
    .regs2_rd_i(regs2_rd_i), .regs2_addr_i(regs2_addr_i),
    .csr_rd_i(csr_rd_i), .csr_wr_i(csr_wr_i),
    .exs_valid_o(exs_valid_o), .exs_ready_i(exs_ready_i),
    .lq_full_i(lq_full_i), .lq_wb_valid_i(lq_wb_valid_i), .lq_wb_addr_i(lq_wb_addr_i),
    .jump_done_i(jump_done_i), .trap_o(trap_o), .trap_ack_i(trap_ack_i),
    .dbg_state_o(dbg_state_o), .dbg_pending_o(dbg_pending_o), .dbg_ld_cnt_o(dbg_ld_cnt_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TAG_W-1:0] cur_tag();
    return {zone_i, regd_addr_i, regs1_addr_i, regs2_addr_i};
  endfunction

  // monitor: every handshake must match the oldest expected instruction
  always @(negedge clk_i) begin
    if (resetb_i && exs_valid_o && exs_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got tag %0h expected none", cur_tag());
      end else begin
        mon_exp = exp_q.pop_front();
        check("issue_tag", 32'(cur_tag()), 32'(mon_exp));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic chk_hs(input string name, input logic ev, input logic ir);
    check({name, " exs_valid"}, 32'(exs_valid_o), 32'(ev));
    check({name, " ids_ready"}, 32'(ids_ready_o), 32'(ir));
  endtask

  task automatic cyc(input string name, input logic ev, input logic ir);
    at_neg();
    chk_hs(name, ev, ir);
    tick();
  endtask

  task automatic clear_ins();
    ids_valid_i = 0; ins_err_i = 0; jump_i = 0; zone_i = ZONE_REGFILE;
    regd_addr_i = 0; regs1_rd_i = 0; regs1_addr_i = 0; regs2_rd_i = 0; regs2_addr_i = 0;
    csr_rd_i = 0; csr_wr_i = 0;
  endtask

  task automatic present(input logic [1:0] zone, input logic [4:0] rd,
                         input logic u1, input logic [4:0] a1,
                         input logic u2, input logic [4:0] a2,
                         input logic jmp, input logic csr, input logic err,
                         input bit expect_issue);
    ids_valid_i = 1; zone_i = zone; regd_addr_i = rd;
    regs1_rd_i = u1; regs1_addr_i = a1; regs2_rd_i = u2; regs2_addr_i = a2;
    jump_i = jmp; csr_rd_i = csr; csr_wr_i = csr; ins_err_i = err;
    if (expect_issue) exp_q.push_back({zone, rd, a1, a2});
  endtask

  initial begin
    clear_ins();
    resetb_i = 0; exs_ready_i = 1; lq_full_i = 0;
    lq_wb_valid_i = 0; lq_wb_addr_i = 0; jump_done_i = 0; trap_ack_i = 0;

    // reset state
    repeat (2) @(posedge clk_i);
    at_neg();
    chk_hs("reset", 0, 0);
    check("reset trap", 32'(trap_o), 0);
    check("reset state", 32'(dbg_state_o), 32'(ISSUE_ST_RUN));
    check("reset pending", dbg_pending_o, 0);
    check("reset ld_cnt", 32'(dbg_ld_cnt_o), 0);
    tick();
    resetb_i = 1;
    tick();

    // 1: lw x5 then dependent add, released the cycle after write-back
    present(ZONE_LOADQ, 5, 1, 2, 0, 0, 0, 0, 0, 1);
    cyc("t1 lw x5", 1, 1);
    present(ZONE_REGFILE, 6, 1, 5, 1, 1, 0, 0, 0, 1);
    at_neg();
    chk_hs("t1 raw stall0", 0, 0);
    check("t1 pending x5", dbg_pending_o, 32'h20);
    check("t1 ld_cnt", 32'(dbg_ld_cnt_o), 1);
    tick();
    cyc("t1 raw stall1", 0, 0);
    lq_wb_valid_i = 1; lq_wb_addr_i = 5;
    cyc("t1 wb no bypass", 0, 0);
    lq_wb_valid_i = 0;
    cyc("t1 add issues", 1, 1);
    clear_ins();
    at_neg();
    check("t1 pending clear", dbg_pending_o, 0);
    check("t1 ld_cnt zero", 32'(dbg_ld_cnt_o), 0);
    tick();

    // execute back-pressure holds the instruction
    exs_ready_i = 0;
    present(ZONE_REGFILE, 10, 1, 3, 0, 0, 0, 0, 0, 1);
    cyc("bp hold0", 1, 0);
    cyc("bp hold1", 1, 0);
    exs_ready_i = 1;
    cyc("bp release", 1, 1);
    clear_ins();

    // 2: load queue depth 4, fifth load held until a write-back retires
    for (int i = 1; i <= 4; i++) begin
      present(ZONE_LOADQ, 5'(i), 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("t2 lw", 1, 1);
    end
    present(ZONE_LOADQ, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    at_neg();
    chk_hs("t2 fifth held", 0, 0);
    check("t2 ld_cnt full", 32'(dbg_ld_cnt_o), 4);
    tick();
    cyc("t2 fifth held1", 0, 0);
    lq_wb_valid_i = 1; lq_wb_addr_i = 1;
    cyc("t2 wb same cycle", 0, 0);
    lq_wb_valid_i = 0;
    cyc("t2 fifth issues", 1, 1);
    clear_ins();
    for (int i = 2; i <= 5; i++) begin
      lq_wb_valid_i = 1; lq_wb_addr_i = 5'(i);
      tick();
    end
    lq_wb_valid_i = 0;
    at_neg();
    check("t2 drained cnt", 32'(dbg_ld_cnt_o), 0);
    check("t2 drained pending", dbg_pending_o, 0);
    tick();

    // 3: beq parks issue until jump_done_i
    present(ZONE_REGFILE, 0, 1, 1, 1, 2, 1, 0, 0, 1);
    cyc("t3 beq", 1, 1);
    present(ZONE_REGFILE, 7, 1, 1, 1, 2, 0, 0, 0, 1);
    at_neg();
    chk_hs("t3 wait1", 0, 0);
    check("t3 state", 32'(dbg_state_o), 32'(ISSUE_ST_JUMP_WAIT));
    tick();
    cyc("t3 wait2", 0, 0);
    jump_done_i = 1;
    cyc("t3 wait3", 0, 0);
    jump_done_i = 0;
    cyc("t3 add after jump", 1, 1);
    clear_ins();
    jump_done_i = 1; trap_ack_i = 1;
    at_neg();
    check("t3 stray pulses state", 32'(dbg_state_o), 32'(ISSUE_ST_RUN));
    check("t3 stray ack no drop", 32'(ids_ready_o), 0);
    tick();
    jump_done_i = 0; trap_ack_i = 0;

    // 4: illegal instruction parks until trap_ack_i
    present(ZONE_REGFILE, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    at_neg();
    chk_hs("t4 err seen", 0, 0);
    check("t4 trap pre", 32'(trap_o), 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk_hs("t4 parked", 0, 0);
      check("t4 trap held", 32'(trap_o), 1);
      tick();
    end
    trap_ack_i = 1;
    at_neg();
    chk_hs("t4 drop", 0, 1);
    check("t4 trap at ack", 32'(trap_o), 1);
    tick();
    trap_ack_i = 0;
    clear_ins();
    at_neg();
    check("t4 trap cleared", 32'(trap_o), 0);
    check("t4 state run", 32'(dbg_state_o), 32'(ISSUE_ST_RUN));
    tick();
    present(ZONE_REGFILE, 4, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc("t4 resume", 1, 1);
    clear_ins();

    // 5: CSR waits for all loads, including a load to x0
    present(ZONE_LOADQ, 8, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("t5 lw x8", 1, 1);
    present(ZONE_LOADQ, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("t5 lw x0", 1, 1);
    present(ZONE_REGFILE, 9, 1, 3, 0, 0, 0, 1, 0, 1);
    at_neg();
    chk_hs("t5 csr stall", 0, 0);
    check("t5 ld_cnt 2", 32'(dbg_ld_cnt_o), 2);
    check("t5 pending x8 only", dbg_pending_o, 32'h100);
    tick();
    lq_wb_valid_i = 1; lq_wb_addr_i = 8;
    cyc("t5 csr stall wb8", 0, 0);
    lq_wb_addr_i = 0;
    at_neg();
    chk_hs("t5 csr stall wb0", 0, 0);
    check("t5 ld_cnt 1", 32'(dbg_ld_cnt_o), 1);
    tick();
    lq_wb_valid_i = 0;
    at_neg();
    chk_hs("t5 csr issues", 1, 1);
    check("t5 ld_cnt 0", 32'(dbg_ld_cnt_o), 0);
    tick();
    clear_ins();

    // 6: asynchronous reset during JUMP_WAIT with a pending load
    present(ZONE_LOADQ, 7, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("t6 lw x7", 1, 1);
    present(ZONE_REGFILE, 0, 1, 1, 0, 0, 1, 0, 0, 1);
    cyc("t6 jal", 1, 1);
    clear_ins();
    at_neg();
    check("t6 pre state", 32'(dbg_state_o), 32'(ISSUE_ST_JUMP_WAIT));
    check("t6 pre pending", dbg_pending_o, 32'h80);
    #1 resetb_i = 0;
    #1;
    chk_hs("t6 in reset", 0, 0);
    check("t6 trap", 32'(trap_o), 0);
    check("t6 state", 32'(dbg_state_o), 32'(ISSUE_ST_RUN));
    check("t6 pending", dbg_pending_o, 0);
    check("t6 ld_cnt", 32'(dbg_ld_cnt_o), 0);
    tick();
    resetb_i = 1;
    present(ZONE_REGFILE, 8, 1, 7, 0, 0, 0, 0, 0, 1);
    cyc("t6 after reset", 1, 1);
    clear_ins();

    at_neg();
    check("exp_q drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
